// File: rtl/in_cvt_cell_if.sv
// -----------------------------------------------------------------------------
// in_cvt_cell_if
//   Element stream bundle for the input conversion cell.
//   Input side : cvt_i_op_x (16), cvt_i_info_along (INFO_ALONG_WIDTH), cvt_i_vld
//   Output side: cvt_o_res (33), cvt_o_info_along (INFO_ALONG_WIDTH), cvt_o_vld
//   master: the producer feeding elements and observing results.
//   slave : the conversion cell itself.
// -----------------------------------------------------------------------------
interface in_cvt_cell_if #(
  parameter int unsigned INFO_ALONG_WIDTH = 2
);
  logic [15:0]                 cvt_i_op_x;
  logic [INFO_ALONG_WIDTH-1:0] cvt_i_info_along;
  logic                        cvt_i_vld;
  logic [32:0]                 cvt_o_res;
  logic [INFO_ALONG_WIDTH-1:0] cvt_o_info_along;
  logic                        cvt_o_vld;

  modport master (
    output cvt_i_op_x, cvt_i_info_along, cvt_i_vld,
    input  cvt_o_res, cvt_o_info_along, cvt_o_vld
  );

  modport slave (
    input  cvt_i_op_x, cvt_i_info_along, cvt_i_vld,
    output cvt_o_res, cvt_o_info_along, cvt_o_vld
  );
endinterface

// File: rtl/in_cvt_cell.sv
// -----------------------------------------------------------------------------
// in_cvt_cell
//   Widens incoming feature/kernel elements into the accumulator domain.
//   Integer formats (U8/S8/U16/S16) become S33 fixed point shifted left by the
//   clamped lshift; FP16 becomes exact FP32 carried as {1'b0, fp32}.
//   Two valid-tagged pipeline stages, global clock enable, no backpressure.
//
// Ports:
//   aclk                      clock
//   areset                    synchronous active-high reset (wins over aclken)
//   aclken                    global clock enable, 0 freezes every register
//   bypass                    1: result = {17'd0, op_x}
//   src_data_fmt              000 U8, 001 S8, 010 U16, 011 S16, 110 FP16,
//                             others NONE (zero-extend)
//   fixed_point_lshift_digits integer left shift, values above 16 clamp to 16
//   cvt                       element stream (in_cvt_cell_if.slave)
// -----------------------------------------------------------------------------
module in_cvt_cell #(
  parameter logic        S33_CVT_SUPPORTED  = 1'b1,
  parameter logic        FP16_CVT_SUPPORTED = 1'b1,
  parameter int unsigned INFO_ALONG_WIDTH   = 2,
  parameter int unsigned SIM_DELAY          = 1
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               aclken,
  input  logic               bypass,
  input  logic [2:0]         src_data_fmt,
  input  logic [4:0]         fixed_point_lshift_digits,
  in_cvt_cell_if.slave       cvt
);

  localparam logic [2:0] FMT_U8   = 3'b000;
  localparam logic [2:0] FMT_S8   = 3'b001;
  localparam logic [2:0] FMT_U16  = 3'b010;
  localparam logic [2:0] FMT_S16  = 3'b011;
  localparam logic [2:0] FMT_FP16 = 3'b110;

  // Registers update with zero delay here; SIM_DELAY is only kept so that
  // existing instantiations that set it still elaborate.
  if (SIM_DELAY > 32'd65535) begin : g_sim_delay_range
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Leading-zero count of a 10-bit mantissa (10 when the mantissa is zero).
  function automatic logic [3:0] lzc10(input logic [9:0] m);
    logic [3:0] cnt;
    casez (m)
      10'b1?????????: cnt = 4'd0;
      10'b01????????: cnt = 4'd1;
      10'b001???????: cnt = 4'd2;
      10'b0001??????: cnt = 4'd3;
      10'b00001?????: cnt = 4'd4;
      10'b000001????: cnt = 4'd5;
      10'b0000001???: cnt = 4'd6;
      10'b00000001??: cnt = 4'd7;
      10'b000000001?: cnt = 4'd8;
      10'b0000000001: cnt = 4'd9;
      default:        cnt = 4'd10;
    endcase
    return cnt;
  endfunction

  // Assemble the exact FP32 image of a decoded FP16 value.
  function automatic logic [31:0] fp32_assemble(
    input logic       s,
    input logic [4:0] e,
    input logic [9:0] m,
    input logic [3:0] lzc
  );
    logic [31:0] r;
    logic [9:0]  m_norm;
    logic [7:0]  exp8;
    r      = 32'd0;
    m_norm = 10'd0;
    exp8   = 8'd0;
    if (e == 5'd0) begin
      if (m == 10'd0) begin
        r = {s, 31'd0};
      end else begin
        // Subnormal: shift the leading one out of the field; what remains is
        // the left-aligned fraction of an FP32 normal.
        m_norm = m << (lzc + 4'd1);
        exp8   = 8'd112 - {4'd0, lzc};
        r      = {s, exp8, m_norm, 13'd0};
      end
    end else if (e == 5'd31) begin
      if (m == 10'd0) begin
        r = {s, 8'hFF, 23'd0};
      end else begin
        // Force quiet, keep the lower payload bits.
        r = {s, 8'hFF, 1'b1, m[8:0], 13'd0};
      end
    end else begin
      exp8 = {3'd0, e} + 8'd112;
      r    = {s, exp8, m, 13'd0};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: extension / FP16 decode
  // ---------------------------------------------------------------------------
  logic                        s1_vld_q,  s1_vld_d;
  logic [32:0]                 s1_ext_q,  s1_ext_d;
  logic                        s1_sign_q, s1_sign_d;
  logic [4:0]                  s1_exp_q,  s1_exp_d;
  logic [9:0]                  s1_man_q,  s1_man_d;
  logic [3:0]                  s1_lzc_q,  s1_lzc_d;
  logic [INFO_ALONG_WIDTH-1:0] s1_info_q, s1_info_d;

  // Stage-1 next state: capture and extend the incoming element when valid.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_ext_d  = s1_ext_q;
    s1_sign_d = s1_sign_q;
    s1_exp_d  = s1_exp_q;
    s1_man_d  = s1_man_q;
    s1_lzc_d  = s1_lzc_q;
    s1_info_d = s1_info_q;
    if (aclken) begin
      s1_vld_d = cvt.cvt_i_vld;
      if (cvt.cvt_i_vld) begin
        s1_info_d = cvt.cvt_i_info_along;
        s1_sign_d = cvt.cvt_i_op_x[15];
        s1_exp_d  = cvt.cvt_i_op_x[14:10];
        s1_man_d  = cvt.cvt_i_op_x[9:0];
        s1_lzc_d  = lzc10(cvt.cvt_i_op_x[9:0]);
        if (bypass) begin
          s1_ext_d = {17'd0, cvt.cvt_i_op_x};
        end else begin
          case (src_data_fmt)
            FMT_U8:   s1_ext_d = S33_CVT_SUPPORTED ?
                                 {25'd0, cvt.cvt_i_op_x[7:0]} : 33'd0;
            FMT_S8:   s1_ext_d = S33_CVT_SUPPORTED ?
                                 {{25{cvt.cvt_i_op_x[7]}}, cvt.cvt_i_op_x[7:0]} : 33'd0;
            FMT_U16:  s1_ext_d = S33_CVT_SUPPORTED ?
                                 {17'd0, cvt.cvt_i_op_x} : 33'd0;
            FMT_S16:  s1_ext_d = S33_CVT_SUPPORTED ?
                                 {{17{cvt.cvt_i_op_x[15]}}, cvt.cvt_i_op_x} : 33'd0;
            FMT_FP16: s1_ext_d = 33'd0;
            default:  s1_ext_d = {17'd0, cvt.cvt_i_op_x};
          endcase
        end
      end else begin
        s1_ext_d = s1_ext_q;
      end
    end else begin
      s1_vld_d = s1_vld_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shift / FP32 assembly, registered outputs
  // ---------------------------------------------------------------------------
  logic [4:0]                  shamt_s;
  logic [32:0]                 s2_res_s;
  logic                        vld_q,  vld_d;
  logic [32:0]                 res_q,  res_d;
  logic [INFO_ALONG_WIDTH-1:0] info_q, info_d;

  // Stage-2 datapath result for the element currently held in stage 1.
  always_comb begin
    if (fixed_point_lshift_digits > 5'd16) begin
      shamt_s = 5'd16;
    end else begin
      shamt_s = fixed_point_lshift_digits;
    end
    if (bypass) begin
      s2_res_s = s1_ext_q;
    end else begin
      case (src_data_fmt)
        FMT_U8, FMT_S8, FMT_U16, FMT_S16:
          // 65535 << 16 stays below 2^32, so a 33-bit shift never overflows.
          s2_res_s = s1_ext_q << shamt_s;
        FMT_FP16:
          s2_res_s = FP16_CVT_SUPPORTED ?
                     {1'b0, fp32_assemble(s1_sign_q, s1_exp_q, s1_man_q, s1_lzc_q)} :
                     33'd0;
        default:
          s2_res_s = s1_ext_q;
      endcase
    end
  end

  // Output-stage next state: load result and side-band when stage 1 is valid.
  always_comb begin
    vld_d  = vld_q;
    res_d  = res_q;
    info_d = info_q;
    if (aclken) begin
      vld_d = s1_vld_q;
      if (s1_vld_q) begin
        res_d  = s2_res_s;
        info_d = s1_info_q;
      end else begin
        res_d  = res_q;
        info_d = info_q;
      end
    end else begin
      vld_d = vld_q;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_vld_q  <= 1'b0;
      s1_ext_q  <= 33'd0;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= 5'd0;
      s1_man_q  <= 10'd0;
      s1_lzc_q  <= 4'd0;
      s1_info_q <= '0;
      vld_q     <= 1'b0;
      res_q     <= 33'd0;
      info_q    <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_ext_q  <= s1_ext_d;
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_man_q  <= s1_man_d;
      s1_lzc_q  <= s1_lzc_d;
      s1_info_q <= s1_info_d;
      vld_q     <= vld_d;
      res_q     <= res_d;
      info_q    <= info_d;
    end
  end

  assign cvt.cvt_o_res        = res_q;
  assign cvt.cvt_o_info_along = info_q;
  assign cvt.cvt_o_vld        = vld_q;

endmodule

// File: tb/tb_in_cvt_cell.sv
module tb_in_cvt_cell;

  logic       aclk = 1'b0;
  logic       areset;
  logic       aclken;
  logic       bypass;
  logic [2:0] src_data_fmt;
  logic [4:0] lshift;

  int checks = 0;
  int errors = 0;

  in_cvt_cell_if #(.INFO_ALONG_WIDTH(2)) cvt_if ();

  in_cvt_cell #(
    .S33_CVT_SUPPORTED (1'b1),
    .FP16_CVT_SUPPORTED(1'b1),
    .INFO_ALONG_WIDTH  (2),
    .SIM_DELAY         (1)
  ) dut (
    .aclk                     (aclk),
    .areset                   (areset),
    .aclken                   (aclken),
    .bypass                   (bypass),
    .src_data_fmt             (src_data_fmt),
    .fixed_point_lshift_digits(lshift),
    .cvt                      (cvt_if)
  );

  always #5 aclk = ~aclk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_fp(input logic [15:0] h);
    logic        s;
    int          e, m, de;
    real         mag;
    logic [63:0] d;
    logic [7:0]  e8;
    s = h[15];
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    if (e == 31) begin
      if (m == 0) return {s, 8'hFF, 23'd0};
      return {s, 8'hFF, 1'b1, h[8:0], 13'd0};
    end
    if (e == 0 && m == 0) return {s, 31'd0};
    if (e == 0) mag = real'(m) * (2.0 ** (-24.0));
    else        mag = (1024.0 + real'(m)) * (2.0 ** real'(e - 25));
    d  = $realtobits(mag);
    de = int'(d[62:52]) - 896;
    e8 = de[7:0];
    return {s, e8, d[51:29]};
  endfunction

  function automatic logic [32:0] ref_cvt(input logic byp, input logic [2:0] fmt,
                                          input logic [4:0] sh, input logic [15:0] x);
    longint      v;
    int          n;
    logic [63:0] t;
    n = (sh > 5'd16) ? 16 : int'(sh);
    if (byp) return {17'd0, x};
    case (fmt)
      3'd0: v = longint'(x[7:0]);
      3'd1: v = longint'(x[7:0]) - (x[7] ? 64'sd256 : 64'sd0);
      3'd2: v = longint'(x);
      3'd3: v = longint'(x) - (x[15] ? 64'sd65536 : 64'sd0);
      3'd6: return {1'b0, ref_fp(x)};
      default: return {17'd0, x};
    endcase
    v = v * (64'sd1 <<< n);
    t = v;
    return t[32:0];
  endfunction

  typedef struct {
    logic        vld;
    logic [32:0] res;
    logic [1:0]  info;
  } item_t;

  item_t       pipe_q[$];
  logic        m_vld  = 1'b0;
  logic [32:0] m_res  = 33'd0;
  logic [1:0]  m_info = 2'd0;

  task automatic model_edge(input logic v, input logic [15:0] x, input logic [1:0] inf);
    item_t it;
    if (areset) begin
      pipe_q.delete();
      m_vld = 1'b0; m_res = 33'd0; m_info = 2'd0;
    end else if (aclken) begin
      it.vld = v; it.res = ref_cvt(bypass, src_data_fmt, lshift, x); it.info = inf;
      pipe_q.push_back(it);
      if (pipe_q.size() > 1) begin
        it = pipe_q.pop_front();
        m_vld = it.vld;
        if (it.vld) begin
          m_res = it.res; m_info = it.info;
        end
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one element for the next edge, step the model, check all outputs.
  task automatic drive_edge(input logic v, input logic [15:0] x, input logic [1:0] inf);
    cvt_if.cvt_i_vld        = v;
    cvt_if.cvt_i_op_x       = x;
    cvt_if.cvt_i_info_along = inf;
    @(posedge aclk);
    model_edge(v, x, inf);
    #1;
    chk("model_vld",  {63'd0, cvt_if.cvt_o_vld}, {63'd0, m_vld});
    chk("model_res",  {31'd0, cvt_if.cvt_o_res}, {31'd0, m_res});
    chk("model_info", {62'd0, cvt_if.cvt_o_info_along}, {62'd0, m_info});
  endtask

  typedef struct {
    logic        byp;
    logic [2:0]  fmt;
    logic [4:0]  sh;
    logic [15:0] x;
    logic [32:0] exp;
  } vec_t;

  vec_t        vecs[12];
  logic [15:0] seq_x[4];
  logic [32:0] seq_e[4];
  logic [2:0]  fmts[8];

  initial begin
    vecs[0]  = '{1'b0, 3'b110, 5'd0,  16'h0001, 33'h0_3380_0000};
    vecs[1]  = '{1'b0, 3'b110, 5'd0,  16'h0200, 33'h0_3800_0000};
    vecs[2]  = '{1'b0, 3'b110, 5'd0,  16'hFC00, 33'h0_FF80_0000};
    vecs[3]  = '{1'b0, 3'b110, 5'd0,  16'h7E00, 33'h0_7FC0_0000};
    vecs[4]  = '{1'b0, 3'b110, 5'd0,  16'h7C01, 33'h0_7FC0_2000};
    vecs[5]  = '{1'b0, 3'b001, 5'd4,  16'h0080, 33'h1_FFFF_F800};
    vecs[6]  = '{1'b0, 3'b000, 5'd4,  16'h12FF, 33'h0_0000_0FF0};
    vecs[7]  = '{1'b0, 3'b011, 5'd16, 16'h8000, 33'h1_8000_0000};
    vecs[8]  = '{1'b0, 3'b010, 5'd20, 16'hFFFF, 33'h0_FFFF_0000};
    vecs[9]  = '{1'b1, 3'b011, 5'd4,  16'hABCD, 33'h0_0000_ABCD};
    vecs[10] = '{1'b0, 3'b111, 5'd4,  16'h8001, 33'h0_0000_8001};
    vecs[11] = '{1'b0, 3'b001, 5'd0,  16'h007F, 33'h0_0000_007F};
    seq_x = '{16'h3C00, 16'hC000, 16'h0000, 16'h8000};
    seq_e = '{33'h0_3F80_0000, 33'h0_C000_0000, 33'h0_0000_0000, 33'h0_8000_0000};
    fmts  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd6, 3'd4, 3'd7};

    areset = 1'b1; aclken = 1'b1; bypass = 1'b0; src_data_fmt = 3'b110; lshift = 5'd0;
    drive_edge(1'b0, 16'h0, 2'd0);
    drive_edge(1'b0, 16'h0, 2'd0);
    chk("reset_vld",  {63'd0, cvt_if.cvt_o_vld}, 64'd0);
    chk("reset_res",  {31'd0, cvt_if.cvt_o_res}, 64'd0);
    chk("reset_info", {62'd0, cvt_if.cvt_o_info_along}, 64'd0);
    areset = 1'b0;
    drive_edge(1'b0, 16'h0, 2'd0);

    // table of single-element vectors, latency 2
    for (int i = 0; i < 12; i++) begin
      bypass = vecs[i].byp; src_data_fmt = vecs[i].fmt; lshift = vecs[i].sh;
      drive_edge(1'b1, vecs[i].x, i[1:0]);
      chk("tbl_early_vld", {63'd0, cvt_if.cvt_o_vld}, 64'd0);
      drive_edge(1'b0, 16'h5A5A, 2'd0);
      chk("tbl_vld", {63'd0, cvt_if.cvt_o_vld}, 64'd1);
      chk("tbl_res", {31'd0, cvt_if.cvt_o_res}, {31'd0, vecs[i].exp});
      chk("tbl_info", {62'd0, cvt_if.cvt_o_info_along}, {62'd0, i[1:0]});
    end

    // back-to-back FP16 stream
    bypass = 1'b0; src_data_fmt = 3'b110; lshift = 5'd0;
    drive_edge(1'b0, 16'h0, 2'd0);
    for (int i = 0; i < 6; i++) begin
      drive_edge(i < 4, (i < 4) ? seq_x[i] : 16'h0, 2'd0);
      if (i >= 1 && i <= 4) begin
        chk("b2b_vld", {63'd0, cvt_if.cvt_o_vld}, 64'd1);
        chk("b2b_res", {31'd0, cvt_if.cvt_o_res}, {31'd0, seq_e[i-1]});
      end else begin
        chk("b2b_idle_vld", {63'd0, cvt_if.cvt_o_vld}, 64'd0);
      end
    end

    // clock enable freeze with two elements in the pipe
    src_data_fmt = 3'b010; lshift = 5'd1;
    drive_edge(1'b1, 16'h0011, 2'b01);
    drive_edge(1'b1, 16'h0022, 2'b10);
    aclken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b1, 16'hFFFF, 2'b11);
      chk("frz_vld",  {63'd0, cvt_if.cvt_o_vld}, 64'd1);
      chk("frz_res",  {31'd0, cvt_if.cvt_o_res}, 64'h22);
      chk("frz_info", {62'd0, cvt_if.cvt_o_info_along}, 64'd1);
    end
    aclken = 1'b1;
    drive_edge(1'b0, 16'h0, 2'b00);
    chk("resume_res",  {31'd0, cvt_if.cvt_o_res}, 64'h44);
    chk("resume_info", {62'd0, cvt_if.cvt_o_info_along}, 64'd2);
    drive_edge(1'b0, 16'h0, 2'b00);
    chk("resume_done_vld", {63'd0, cvt_if.cvt_o_vld}, 64'd0);

    // reset while elements are in flight
    drive_edge(1'b1, 16'h1234, 2'b01);
    areset = 1'b1;
    drive_edge(1'b1, 16'h5678, 2'b10);
    areset = 1'b0;
    chk("rst_mid_vld", {63'd0, cvt_if.cvt_o_vld}, 64'd0);
    chk("rst_mid_res", {31'd0, cvt_if.cvt_o_res}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0, 16'h0, 2'b00);
      chk("rst_drop_vld", {63'd0, cvt_if.cvt_o_vld}, 64'd0);
    end

    // randomized blocks against the reference model
    for (int b = 0; b < 24; b++) begin
      bypass       = ($urandom_range(0, 7) == 0);
      src_data_fmt = fmts[$urandom_range(0, 7)];
      lshift       = 5'($urandom_range(0, 31));
      for (int c = 0; c < 30; c++) begin
        aclken = ($urandom_range(0, 3) != 0);
        areset = ($urandom_range(0, 63) == 0);
        drive_edge(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom));
      end
      areset = 1'b0; aclken = 1'b1;
      drive_edge(1'b0, 16'h0, 2'd0);
      drive_edge(1'b0, 16'h0, 2'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/in_cvt_cell.md
Name: in_cvt_cell

Overview:
- Input-side counterpart of the output rounding cell: widens incoming feature/kernel elements into the accumulator domain before the MAC array.
- Integer formats (U8/S8/U16/S16) become S33 fixed point, left-shifted to the accumulator quantisation accuracy. FP16 becomes exact FP32, carried as {1'b0, fp32}.
- Pipeline is a 2-stage valid-tagged datapath with global clock enable and side-band info.

Parameters:
- S33_CVT_SUPPORTED, 1'b1, enable integer to S33 path; when 0, integer formats output 33'd0.
- FP16_CVT_SUPPORTED, 1'b1, enable FP16 to FP32 path; when 0, FP16 outputs 33'd0.
- INFO_ALONG_WIDTH, 2, width of side-band data travelling with each element.
- SIM_DELAY, 1, register update delay for simulation only.

Ports:
- aclk  in  1  clock
- areset  in  1  reset, synchronous, active-high
- aclken  in  1  global clock enable; 0 freezes every pipeline register
- bypass  in  1  1: output = {17'd0, cvt_i_op_x}, same latency
- src_data_fmt  in  3  000 U8, 001 S8, 010 U16, 011 S16, 110 FP16, others = NONE (zero-extend, like bypass)
- fixed_point_lshift_digits  in  5  integer left-shift 0..16; values >16 clamp to 16
- cvt_i_op_x  in  16  input element; 8-bit formats use [7:0], [15:8] ignored
- cvt_i_info_along  in  INFO_ALONG_WIDTH  side-band in
- cvt_i_vld  in  1  input valid
- cvt_o_res  out  33  S33 result, or {1'b0, fp32}
- cvt_o_info_along  out  INFO_ALONG_WIDTH  side-band out
- cvt_o_vld  out  1  output valid

Behaviour:
- Reset (areset=1 at a posedge): both stage valids clear; cvt_o_vld=0; cvt_o_res=0; cvt_o_info_along=0. Reset wins over aclken.
- Reset mid-operation: all in-flight elements are dropped, with no output pulse for them.
- Latency and throughput: exactly 2 enabled cycles, input at edge N gives output after edge N+1. Accepts one element per enabled cycle; no backpressure.
- Clock enable: aclken=0 holds all data, valids and info unchanged, including cvt_o_vld.
- Data registers load only when the matching stage valid is set; info_along follows the data exactly.
- Configuration: src_data_fmt, bypass and lshift are quasi-static and must not change while any stage valid is 1. Results are undefined if they do.
- Integer path:
  - Stage 1 sign-extends (S8/S16) or zero-extends (U8/U16) to 33 bits.
  - Stage 2 shifts left by the clamped lshift.
  - Max magnitude 65535<<16 < 2^32, so there is no overflow and no saturation.
- FP16 path, stage 1: decode s/e/m and compute the leading-zero count of the 10-bit mantissa (subnormal case only).
- FP16 path, stage 2 assembles FP32:
  - zero (e=0, m=0): {s, 31'd0}, signed zero preserved.
  - normal: exp = e+112, mant = m<<13.
  - subnormal: normalise m; exp = 113 - (lzc+1); mant = remaining bits left-aligned. The result is always an FP32 normal and exact.
  - inf (e=31, m=0): {s, 8'hFF, 23'd0}.
  - NaN (e=31, m!=0): {s, 8'hFF, 1'b1, m[8:0], 13'd0}, always quiet, payload kept.
- Output format: bit 32 of cvt_o_res is 0 for FP16, NONE and bypass.

Test Plan:
- FP16 0x3C00, 0xC000, 0x0000, 0x8000 with vld 1 cycle apart -> 0x3F800000, 0xC0000000, 0x00000000, 0x80000000; each 2 cycles after input, back-to-back vld.
- FP16 subnormals 0x0001 -> 0x33800000 and 0x0200 -> 0x38000000. FP16 0xFC00 -> 0xFF800000; 0x7E00 -> 0x7FC00000; 0x7C01 -> 0x7FC02000.
- Integer, lshift=4:
  - S8 0x80 -> 33'h1_FFFF_F800 (-2048).
  - U8 0xFF -> 33'h0_0000_0FF0.
  - S16 0x8000, lshift=16 -> 33'h1_8000_0000.
  - lshift=20 with U16 0xFFFF -> 33'h0_FFFF_0000 (clamped to 16).
- aclken low 3 cycles while 2 elements are in flight -> outputs frozen, no duplicate vld; on resume both emerge in order. info_along 2'b01/2'b10 tracks its element.
- areset asserted 1 cycle with 2 elements in flight -> cvt_o_vld=0 and cvt_o_res=0 next cycle; neither element ever appears. bypass=1 with 0xABCD -> 33'h0_0000_ABCD at latency 2.
